code_digit_collector: RTL and testbench
=======================================

// Module: code_digit_collector
// PURPOSE
//  Downstream stage of the BCD-to-code converter. Accepts one 4-bit coded digit per transfer,
//  decodes it back to BCD, and packs NDIGITS digits (most significant digit first) into one BCD word.
//  Presents the word with a valid/ready handshake. Flags any non-code input and holds the error until cleared.
// PARAMETERS
//  NDIGITS  4  digits per packed word (>=2)
//  CNT_W    3  width of digit_cnt; must hold 0..NDIGITS-1
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  in_code    in   4          coded digit
//  in_valid   in   1          in_code is valid
//  in_ready   out  1          block can accept in_code
//  clear      in   1          synchronous abort/clear, 1-cycle pulse
//  bcd_out    out  4*NDIGITS  packed BCD word, digit 0 in [3:0]
//  out_valid  out  1          bcd_out holds a completed word
//  out_ready  in   1          consumer takes bcd_out
//  err        out  1          illegal code received (sticky)
//  digit_cnt  out  CNT_W      digits accepted for the current word
// BEHAVIOUR
//  Decode table: 0000->0, 0111->1, 0110->2, 0101->3, 0100->4, 1011->5, 1010->6, 1001->7, 1000->8, 1111->9.
//  Illegal codes: 0001, 0010, 0011, 1100, 1101, 1110.
//  Reset (async, rst_n=0) sets: state=COLLECT, accumulator=0, bcd_out=0, out_valid=0, err=0, digit_cnt=0.
//  in_ready = (state==COLLECT); combinational from state only.
//  Transfer = in_valid & in_ready at the rising clk edge.
//  States:
//   - COLLECT, legal transfer: acc <= {acc[4*NDIGITS-5:0], digit}; digit_cnt++.
//   - COLLECT, legal transfer with digit_cnt==NDIGITS-1:
//     bcd_out <= shifted acc; out_valid <= 1; acc <= 0; digit_cnt <= 0; go to HOLD.
//     out_valid rises the cycle after the last digit is accepted (latency 1).
//   - COLLECT, illegal transfer: err <= 1; acc <= 0; digit_cnt <= 0; go to ERROR.
//     The partial word is discarded.
//   - HOLD: in_ready=0; bcd_out and out_valid are stable.
//     On out_ready: out_valid <= 0 and go to COLLECT. in_ready is 1 the next cycle.
//     bcd_out keeps the last word until the next completion.
//   - ERROR: in_ready=0; err=1; out_valid=0. Leaves only on clear.
//  clear (highest priority, any state): acc <= 0; digit_cnt <= 0; err <= 0; out_valid <= 0;
//   go to COLLECT. bcd_out is unchanged. A transfer in the same cycle as clear is dropped.
//  out_ready is ignored outside HOLD. in_code is ignored unless there is a transfer.
//  Max throughput: NDIGITS+1 cycles per word (one HOLD cycle with out_ready=1).
//  No X on outputs after reset; an unused state encoding returns to COLLECT.
// TESTING
//  1) Reset: send 2 digits, pulse rst_n low mid-word.
//     -> all outputs 0 immediately, in_ready=1. The next 4 digits form a full fresh word.
//  2) Send 0111,0110,0101,0100 with out_ready=0 for 5 cycles.
//     -> bcd_out=16'h1234 and out_valid=1 one cycle after the 4th digit. Value held, in_ready=0.
//     -> out_ready=1 -> out_valid=0 next cycle.
//  3) Send 1111,1000,0000,1011 with in_valid and out_ready held at 1.
//     -> bcd_out=16'h9805. The next word starts after exactly one HOLD cycle.
//  4) Send 0111,0110, then 1100.
//     -> err=1, in_ready=0, digit_cnt=0. Stays until clear.
//     -> clear -> err=0. Then 1001,1010,1011,0100 -> 16'h7654.
//  5) Send 0111, then clear and in_valid=1 (0110) in the same cycle.
//     -> digit dropped, digit_cnt=0. The next 4 digits give a word with no residue of 1.
//  6) Drive all 16 codes one per word slot.
//     -> the 10 legal codes decode per the table. Each of the 6 illegal codes sets err.

Source files
------------

// File: rtl/code_digit_collector.sv
`default_nettype none
// ============================================================================
// code_digit_collector : decodes 4-bit coded digits to BCD and packs
//                        NDIGITS of them (MSD first) into a handshaked word.
// Revision: 1.0
// ============================================================================
module code_digit_collector #(
    parameter int NDIGITS = 4,
    parameter int CNT_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             in_code,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   clear,
    output logic [4*NDIGITS-1:0]   bcd_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err,
    output logic [CNT_W-1:0]       digit_cnt
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        ERROR   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NDIGITS - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t                 r_state;
    logic [4*NDIGITS-1:0]   r_acc;
    logic [3:0]             w_digit;
    logic                   w_legal;
    logic [4*NDIGITS-1:0]   w_shifted;

    always_comb begin
        w_digit = 4'd0;
        w_legal = 1'b1;
        case (in_code)
            4'b0000: w_digit = 4'd0;
            4'b0111: w_digit = 4'd1;
            4'b0110: w_digit = 4'd2;
            4'b0101: w_digit = 4'd3;
            4'b0100: w_digit = 4'd4;
            4'b1011: w_digit = 4'd5;
            4'b1010: w_digit = 4'd6;
            4'b1001: w_digit = 4'd7;
            4'b1000: w_digit = 4'd8;
            4'b1111: w_digit = 4'd9;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_shifted = {r_acc[4*NDIGITS-5:0], w_digit};
    assign in_ready  = (r_state == COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= COLLECT;
            r_acc     <= '0;
            bcd_out   <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            digit_cnt <= '0;
        end else if (clear) begin
            // Abort wins over everything, including a same-cycle transfer.
            r_state   <= COLLECT;
            r_acc     <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            digit_cnt <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (in_valid) begin
                        if (!w_legal) begin
                            err       <= 1'b1;
                            r_acc     <= '0;
                            digit_cnt <= '0;
                            r_state   <= ERROR;
                        end else if (digit_cnt == C_LAST) begin
                            bcd_out   <= w_shifted;
                            out_valid <= 1'b1;
                            r_acc     <= '0;
                            digit_cnt <= '0;
                            r_state   <= HOLD;
                        end else begin
                            r_acc     <= w_shifted;
                            digit_cnt <= digit_cnt + C_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= COLLECT;
                    end
                end
                ERROR: begin
                    out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= COLLECT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_code_digit_collector.sv
`default_nettype none
// ============================================================================
// tb_code_digit_collector : scoreboard bench with a list-based digit model.
// Revision: 1.0
// ============================================================================
module tb_code_digit_collector;

    localparam int NDIGITS = 4;
    localparam int CNT_W   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           in_code;
    logic                 in_valid;
    logic                 in_ready;
    logic                 clear;
    logic [4*NDIGITS-1:0] bcd_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 err;
    logic [CNT_W-1:0]     digit_cnt;

    code_digit_collector #(.NDIGITS(NDIGITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear), .bcd_out(bcd_out),
        .out_valid(out_valid), .out_ready(out_ready), .err(err),
        .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ready_mode = 0;               // 0 random, 1 forced low, 2 forced high
    logic [3:0] legal_codes [10] = '{4'b0000, 4'b0111, 4'b0110, 4'b0101, 4'b0100,
                                     4'b1011, 4'b1010, 4'b1001, 4'b1000, 4'b1111};
    int digits [$];
    int exp_q  [$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [3:0] c);
        for (int i = 0; i < 10; i++)
            if (c == legal_codes[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL word_unexpected: actual=%0h expected=none", bcd_out);
            end else begin
                check("word", int'(bcd_out), exp_q.pop_front());
            end
        end
    end

    // Starts and ends just after a rising edge.
    task automatic send_digit(input logic [3:0] code);
        int n = 0;
        int d;
        int w;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        in_code  = code;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_code  = 4'($urandom);
        d = decode(code);
        if (d < 0) begin
            digits.delete();
            check("err_set", int'(err), 1);
            check("err_in_ready", int'(in_ready), 0);
            check("err_cnt", int'(digit_cnt), 0);
            repeat (2) @(posedge clk);
            #1;
            check("err_sticky", int'(err), 1);
            clear = 1'b1;
            @(posedge clk); #1;
            clear = 1'b0;
            check("err_cleared", int'(err), 0);
            check("err_ready_back", int'(in_ready), 1);
        end else begin
            digits.push_back(d);
            if (digits.size() == NDIGITS) begin
                w = 0;
                foreach (digits[i]) w = w * 16 + digits[i];
                exp_q.push_back(w);
                digits.delete();
                check("done_valid", int'(out_valid), 1);
                check("done_in_ready", int'(in_ready), 0);
                check("done_cnt", int'(digit_cnt), 0);
            end else begin
                check("digit_cnt", int'(digit_cnt), digits.size());
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_code = 4'd0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_bcd", int'(bcd_out), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Async reset mid-word discards the partial digits.
        send_digit(4'b0111);
        send_digit(4'b0110);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_cnt", int'(digit_cnt), 0);
        check("midrst_ready", int'(in_ready), 1);
        check("midrst_valid", int'(out_valid), 0);
        #1 rst_n = 1'b1;
        digits.delete();
        @(posedge clk); #1;
        foreach (legal_codes[i]) if (i >= 5 && i <= 8) send_digit(legal_codes[i]);
        drain();

        // 1234 held while the consumer stalls.
        ready_mode = 1;
        @(posedge clk); #1;
        send_digit(4'b0111); send_digit(4'b0110); send_digit(4'b0101); send_digit(4'b0100);
        check("word_1234", int'(bcd_out), 16'h1234);
        repeat (5) @(posedge clk);
        #1;
        check("hold_valid", int'(out_valid), 1);
        check("hold_ready", int'(in_ready), 0);
        check("hold_word", int'(bcd_out), 16'h1234);
        ready_mode = 2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("released_valid", int'(out_valid), 0);
        drain();

        // Back-to-back: exactly one HOLD cycle between words.
        send_digit(4'b1111); send_digit(4'b1000); send_digit(4'b0000); send_digit(4'b1011);
        check("word_9805", int'(bcd_out), 16'h9805);
        @(posedge clk); #1;
        check("one_hold_cycle", int'(in_ready), 1);
        drain();

        // Illegal code mid-word, then a fresh word.
        send_digit(4'b0111); send_digit(4'b0110); send_digit(4'b1100);
        send_digit(4'b1001); send_digit(4'b1010); send_digit(4'b1011); send_digit(4'b0100);
        check("word_7654", int'(bcd_out), 16'h7654);
        drain();

        // Clear coinciding with a transfer drops the digit.
        send_digit(4'b0111);
        in_code = 4'b0110; in_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0;
        digits.delete();
        check("clear_drop_cnt", int'(digit_cnt), 0);
        send_digit(4'b0101); send_digit(4'b0100); send_digit(4'b1011); send_digit(4'b1010);
        check("word_3456", int'(bcd_out), 16'h3456);
        drain();

        // Every code once, padded to whole words.
        for (int c = 0; c < 16; c++) send_digit(4'(c));
        while (digits.size() != 0) send_digit(legal_codes[$urandom_range(0, 9)]);
        drain();

        // Randomized traffic with random consumer stalls.
        ready_mode = 0;
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            if ($urandom_range(0, 19) == 0)
                send_digit(4'($urandom_range(1, 3)) | 4'($urandom_range(0, 1) * 12));
            else
                send_digit(legal_codes[$urandom_range(0, 9)]);
        end
        while (digits.size() != 0) send_digit(legal_codes[$urandom_range(0, 9)]);
        ready_mode = 2;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
